// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor holding msip, the 64-bit mtime and mtimecmp; drives IRQ3/IRQ7
//   clk, resetn          : clock, synchronous active-low reset
//   valid, sel           : bus request (held until ready) and CLINT window hit
//   addr, wstrb, wdata   : byte offset (bits [1:0] ignored), byte strobes (0 = read), write data
//   rdata, ready         : one-cycle response, rdata is 0 whenever ready is low
//   IRQ3, IRQ7           : machine software / timer interrupts
//   mtime                : live mtime for the time/timeh CSRs
module clint_timer #(
  parameter int unsigned PRESCALE = 1,
  parameter logic [63:0] MTIMECMP_INIT = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic        sel,
  input  logic [15:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        IRQ3,
  output logic        IRQ7,
  output logic [63:0] mtime
);
  localparam logic [15:0] LAST = 16'(PRESCALE - 1);
  logic        r_msip;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [15:0] r_pre;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_irq7;
  logic        w_req;
  logic        w_wr;
  logic        w_tick;
  logic        w_msip_sel;
  logic        w_cmpl;
  logic        w_cmph;
  logic        w_timel;
  logic        w_timeh;
  logic [31:0] w_rd;
  logic [63:0] w_mtime_nxt;
  logic        w_unused;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) merge[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
  endfunction

  // ready blocks a second request in the response cycle, giving one response per 2 cycles
  assign w_req      = valid & sel & ~r_ready;
  assign w_wr       = w_req & |wstrb;
  assign w_tick     = r_pre == LAST;
  assign w_msip_sel = addr[15:2] == 14'h0000;
  assign w_cmpl     = addr[15:2] == 14'h1000;
  assign w_cmph     = addr[15:2] == 14'h1001;
  assign w_timel    = addr[15:2] == 14'h2FFE;
  assign w_timeh    = addr[15:2] == 14'h2FFF;
  assign w_unused   = ^addr[1:0];

  always_comb
    w_rd = w_msip_sel ? {31'b0, r_msip} :
           w_cmpl     ? r_mtimecmp[31:0] :
           w_cmph     ? r_mtimecmp[63:32] :
           w_timel    ? r_mtime[31:0] :
           w_timeh    ? r_mtime[63:32] : 32'h0;

  // a bus write to either mtime word suppresses that cycle's increment entirely
  always_comb
    w_mtime_nxt = (w_wr & w_timel) ? {r_mtime[63:32], merge(r_mtime[31:0], wdata, wstrb)} :
                  (w_wr & w_timeh) ? {merge(r_mtime[63:32], wdata, wstrb), r_mtime[31:0]} :
                  r_mtime + {63'b0, w_tick};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_msip     <= 1'b0;
      r_mtime    <= 64'h0;
      r_mtimecmp <= MTIMECMP_INIT;
      r_pre      <= 16'h0;
      r_ready    <= 1'b0;
      r_rdata    <= 32'h0;
      r_irq7     <= 1'b0;
    end else begin
      r_ready <= w_req;
      r_rdata <= (w_req & ~|wstrb) ? w_rd : 32'h0;
      r_pre   <= w_tick ? 16'h0 : r_pre + 16'h1;
      r_mtime <= w_mtime_nxt;
      r_irq7  <= r_mtime >= r_mtimecmp;
      if (w_wr & w_msip_sel & wstrb[0]) r_msip <= wdata[0];
      if (w_wr & w_cmpl) r_mtimecmp[31:0] <= merge(r_mtimecmp[31:0], wdata, wstrb);
      if (w_wr & w_cmph) r_mtimecmp[63:32] <= merge(r_mtimecmp[63:32], wdata, wstrb);
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign IRQ3  = r_msip;
  assign IRQ7  = r_irq7;
  assign mtime = r_mtime;
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed table-driven bench for clint_timer with PRESCALE=4
module tb_clint_timer;
  logic        clk = 1'b0;
  logic        resetn, valid, sel;
  logic [15:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata, rdata;
  logic        ready, IRQ3, IRQ7;
  logic [63:0] mtime;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] rd;
    logic        irq3;
  } vec_t;
  vec_t tbl[20];

  clint_timer #(.PRESCALE(4)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .sel(sel), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .rdata(rdata), .ready(ready), .IRQ3(IRQ3), .IRQ7(IRQ7), .mtime(mtime)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= resetn ? cyc + 1 : 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic bus(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d, output logic [31:0] q);
    logic got;
    got = 1'b0;
    q = 32'h0;
    lat = 0;
    @(negedge clk);
    valid = 1'b1; sel = 1'b1; addr = a; wstrb = s; wdata = d;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ready) begin
        got = 1'b1;
        q = rdata;
      end
    end
    valid = 1'b0; sel = 1'b0; wstrb = 4'h0;
    chk("ready_seen", {63'b0, got}, 64'd1);
  endtask

  task automatic do_reset;
    @(negedge clk);
    resetn = 1'b0; valid = 1'b0; sel = 1'b0; wstrb = 4'h0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] q;
    logic [63:0] prev;
    int hi;
    tbl[0]  = '{16'h0000, 4'hF, 32'h0000_0001, 32'h0, 1'b1};
    tbl[1]  = '{16'h0000, 4'h0, 32'h0, 32'h0000_0001, 1'b1};
    tbl[2]  = '{16'h0000, 4'hF, 32'hFFFF_FFFE, 32'h0, 1'b0};
    tbl[3]  = '{16'h0000, 4'h0, 32'h0, 32'h0000_0000, 1'b0};
    tbl[4]  = '{16'h0000, 4'h1, 32'h0000_0001, 32'h0, 1'b1};
    tbl[5]  = '{16'h0000, 4'h2, 32'h0000_0000, 32'h0, 1'b1};
    tbl[6]  = '{16'h0000, 4'h0, 32'h0, 32'h0000_0001, 1'b1};
    tbl[7]  = '{16'h0000, 4'hF, 32'h0000_0000, 32'h0, 1'b0};
    tbl[8]  = '{16'h4004, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0};
    tbl[9]  = '{16'h4000, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0};
    tbl[10] = '{16'h4000, 4'hF, 32'h1234_5678, 32'h0, 1'b0};
    tbl[11] = '{16'h4000, 4'h2, 32'h0000_AB00, 32'h0, 1'b0};
    tbl[12] = '{16'h4000, 4'h0, 32'h0, 32'h1234_AB78, 1'b0};
    tbl[13] = '{16'h4004, 4'hC, 32'hA5A5_0000, 32'h0, 1'b0};
    tbl[14] = '{16'h4004, 4'h0, 32'h0, 32'hA5A5_FFFF, 1'b0};
    tbl[15] = '{16'h1234, 4'h0, 32'h0, 32'h0000_0000, 1'b0};
    tbl[16] = '{16'h1234, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
    tbl[17] = '{16'h1234, 4'h0, 32'h0, 32'h0000_0000, 1'b0};
    tbl[18] = '{16'h4003, 4'h0, 32'h0, 32'h1234_AB78, 1'b0};
    tbl[19] = '{16'h0002, 4'h0, 32'h0, 32'h0000_0000, 1'b0};
    resetn = 1'b0; valid = 1'b0; sel = 1'b0; addr = 16'h0; wstrb = 4'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'b0, ready}, 64'd0);
    chk("rst_rdata", {32'b0, rdata}, 64'd0);
    chk("rst_irq3", {63'b0, IRQ3}, 64'd0);
    chk("rst_irq7", {63'b0, IRQ7}, 64'd0);
    chk("rst_mtime", mtime, 64'd0);
    resetn = 1'b1;
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      hi += int'(IRQ7);
    end
    chk("irq7_quiet_1000", 64'(hi), 64'd0);
    chk("mtime_port_count", mtime, 64'(cyc / 4));
    bus(16'hBFF8, 4'h0, 32'h0, q);
    chk("mtime_lo_count", {32'b0, q}, 64'((cyc - 1) / 4));
    bus(16'hBFFC, 4'h0, 32'h0, q);
    chk("mtime_hi_zero", {32'b0, q}, 64'd0);
    for (int i = 0; i < 20; i++) begin
      bus(tbl[i].a, tbl[i].s, tbl[i].d, q);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd1);
      chk($sformatf("tbl%0d_irq3", i), {63'b0, IRQ3}, {63'b0, tbl[i].irq3});
      if (tbl[i].s == 4'h0) chk($sformatf("tbl%0d_rdata", i), {32'b0, q}, {32'b0, tbl[i].rd});
    end
    @(negedge clk);
    valid = 1'b1; sel = 1'b1; addr = 16'h4000; wstrb = 4'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("burst%0d_ready", i), {63'b0, ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("burst%0d_rdata", i), {32'b0, rdata}, (i % 2 == 0) ? 64'h1234_AB78 : 64'd0);
    end
    sel = 1'b0;
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      hi += int'(ready);
    end
    chk("nosel_no_ready", 64'(hi), 64'd0);
    valid = 1'b0;
    do_reset();
    bus(16'h4004, 4'hF, 32'h0, q);
    bus(16'h4000, 4'hF, 32'd10, q);
    for (int i = 0; i < 200 && !IRQ7; i++) @(negedge clk);
    chk("irq7_rise", {63'b0, IRQ7}, 64'd1);
    chk("irq7_rise_cycle", 64'(cyc), 64'd41);
    bus(16'h4004, 4'hF, 32'h1, q);
    chk("irq7_hold_on_write", {63'b0, IRQ7}, 64'd1);
    @(negedge clk);
    chk("irq7_drop", {63'b0, IRQ7}, 64'd0);
    bus(16'hBFFC, 4'hF, 32'h0, q);
    bus(16'hBFF8, 4'hF, 32'hFFFF_FFFE, q);
    chk("mtime_lo_written", mtime, 64'h0000_0000_FFFF_FFFE);
    prev = mtime;
    for (int i = 0; i < 40 && mtime[63:32] == 32'h0; i++) begin
      prev = mtime;
      @(negedge clk);
    end
    chk("carry_before", prev, 64'h0000_0000_FFFF_FFFF);
    chk("carry_after", mtime, 64'h0000_0001_0000_0000);
    bus(16'hBFFC, 4'h0, 32'h0, q);
    chk("carry_hi_read", {32'b0, q}, 64'd1);
    bus(16'hBFFC, 4'hF, 32'hFFFF_FFFF, q);
    bus(16'hBFF8, 4'hF, 32'hFFFF_FFFF, q);
    chk("wrap_all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    prev = mtime;
    for (int i = 0; i < 10 && mtime == prev; i++) @(negedge clk);
    chk("wrap_to_zero", mtime, 64'h0);
    prev = mtime;
    for (int i = 0; i < 10 && mtime == prev; i++) @(negedge clk);
    chk("tick_found", {63'b0, mtime != prev}, 64'd1);
    repeat (3) @(negedge clk);
    valid = 1'b1; sel = 1'b1; addr = 16'hBFF8; wstrb = 4'hF; wdata = 32'h5555_0000;
    @(negedge clk);
    valid = 1'b0; sel = 1'b0; wstrb = 4'h0;
    chk("tickwr_ready", {63'b0, ready}, 64'd1);
    chk("tickwr_value", mtime, 64'h0000_0000_5555_0000);
    repeat (3) @(negedge clk);
    chk("tickwr_hold", mtime, 64'h0000_0000_5555_0000);
    @(negedge clk);
    chk("tickwr_next_tick", mtime, 64'h0000_0000_5555_0001);
    bus(16'h0000, 4'hF, 32'h1, q);
    chk("pre_rst_irq3", {63'b0, IRQ3}, 64'd1);
    @(negedge clk);
    resetn = 1'b0; valid = 1'b1; sel = 1'b1; addr = 16'h4000; wstrb = 4'hF; wdata = 32'h0;
    @(negedge clk);
    chk("midrst_ready", {63'b0, ready}, 64'd0);
    chk("midrst_irq3", {63'b0, IRQ3}, 64'd0);
    chk("midrst_irq7", {63'b0, IRQ7}, 64'd0);
    chk("midrst_mtime", mtime, 64'd0);
    valid = 1'b0; sel = 1'b0; wstrb = 4'h0;
    resetn = 1'b1;
    bus(16'h4000, 4'h0, 32'h0, q);
    chk("midrst_cmp_lo", {32'b0, q}, 64'hFFFF_FFFF);
    bus(16'h4004, 4'h0, 32'h0, q);
    chk("midrst_cmp_hi", {32'b0, q}, 64'hFFFF_FFFF);
    bus(16'h0000, 4'h0, 32'h0, q);
    chk("midrst_msip", {32'b0, q}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
